// File: rtl/data_compare_pkg.sv
// Shared result codes and FSM encoding for the sliced magnitude comparator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_compare_pkg;

  // Result codes, one-hot {gt,eq,lt}; all-zero means no decision made yet
  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Build a result code from separate greater/less flags (neither set = equal)
  function automatic logic [2:0] cmpCode(input logic gt, input logic lt);
    logic [2:0] code;
    code = CMP_EQ;
    if (gt) begin
      code = CMP_GT;
    end else if (lt) begin
      code = CMP_LT;
    end
    return code;
  endfunction

endpackage

// File: rtl/data_compare_chunk.sv
// Combinational CHUNK-bit compare of one operand slice, optionally two's-complement.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
module data_compare_chunk
  import data_compare_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             isSigned,
  output logic [2:0]       code
);

  logic gt;
  logic lt;

  // Signed compare only for the top slice of a signed operation; lower slices are plain magnitude
  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    if (isSigned) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    code = cmpCode(gt, lt);
  end

endmodule

// File: rtl/data_compare_seq.sv
// Multi-cycle wide magnitude comparator: one CHUNK slice per clock, MSB slice first, early exit on first difference.
// Latency: oDone pulses k edges after the accepting edge, k = slices examined (1..WIDTH/CHUNK).
// Backpressure: iStart is ignored while busy; result holds until the next decision. Signed top slice under DATA_COMPARE_SIGNED_EN.
module data_compare_seq
  import data_compare_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                             iClk,
  input  logic                             iRst,
  input  logic                             iStart,
`ifdef DATA_COMPARE_SIGNED_EN
  input  logic                             iSigned,
`endif
  input  logic [WIDTH-1:0]                 iData_a,
  input  logic [WIDTH-1:0]                 iData_b,
  output logic                             oBusy,
  output logic                             oDone,
  output logic [2:0]                       oData,
  output logic [$clog2(WIDTH/CHUNK):0]     oCycles
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N) + 1;

  // Operands must split into a whole number of slices
  generate
    if ((CHUNK < 1) || (N < 1) || ((WIDTH % CHUNK) != 0)) begin : gBadParams
      $error("data_compare_seq: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             sgnLat;
  logic             startSigned;
  logic             topSlice;
  logic             lastSlice;
  logic             decide;
  logic [2:0]       sliceCode;

`ifdef DATA_COMPARE_SIGNED_EN
  assign startSigned = iSigned;
`else
  assign startSigned = 1'b0;
`endif

  // The latched operands are shifted left after each equal slice, so the slice
  // under test is always the top CHUNK bits; idx tracks which original slice that is.
  assign topSlice  = (idx == IW'(N - 1));
  assign lastSlice = (idx == '0);

  data_compare_chunk #(
    .CHUNK(CHUNK)
  ) uChunk (
    .a        (opA[WIDTH-1 -: CHUNK]),
    .b        (opB[WIDTH-1 -: CHUNK]),
    .isSigned (sgnLat & topSlice),
    .code     (sliceCode)
  );

  // A slice that differs settles the result; reaching slice 0 still equal means the operands match
  assign decide = (sliceCode != CMP_EQ) || lastSlice;

  // Controller: accept in IDLE/DONE, walk slices in CMP, pulse oDone and hold result in DONE
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= IDLE;
      opA     <= '0;
      opB     <= '0;
      idx     <= '0;
      cnt     <= '0;
      sgnLat  <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oData   <= CMP_NONE;
      oCycles <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (iStart) begin
            opA    <= iData_a;
            opB    <= iData_b;
            sgnLat <= startSigned;
            idx    <= IW'(N - 1);
            cnt    <= '0;
            oBusy  <= 1'b1;
            state  <= CMP;
          end else begin
            state <= IDLE;
          end
        end
        CMP: begin
          if (decide) begin
            oData   <= sliceCode;
            oCycles <= cnt + CW'(1);
            oDone   <= 1'b1;
            oBusy   <= 1'b0;
            state   <= DONE;
          end else begin
            opA <= opA << CHUNK;
            opB <= opB << CHUNK;
            idx <= idx - IW'(1);
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_compare_seq.sv
// Directed bench for data_compare_seq: per-cycle check against a slice-walking reference model,
// plus literal expectations for latency, hold, restart, reset abort, signed mode and an 8-bit build.
module tb_data_compare_seq;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iStart;
  logic        iSignedIn;
  logic [31:0] iData_a;
  logic [31:0] iData_b;
  logic        oBusy;
  logic        oDone;
  logic [2:0]  oData;
  logic [2:0]  oCycles;

  logic        iStart8;
  logic [7:0]  iA8;
  logic [7:0]  iB8;
  logic        oBusy8;
  logic        oDone8;
  logic [2:0]  oData8;
  logic [0:0]  oCycles8;

  int nTests = 0;
  int nFail  = 0;
  bit chkEn  = 1'b0;

  always #5 iClk = ~iClk;

  data_compare_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iStart  (iStart),
`ifdef DATA_COMPARE_SIGNED_EN
    .iSigned (iSignedIn),
`endif
    .iData_a (iData_a),
    .iData_b (iData_b),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oData   (oData),
    .oCycles (oCycles)
  );

  data_compare_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .iClk    (iClk),
    .iRst    (iRst),
    .iStart  (iStart8),
`ifdef DATA_COMPARE_SIGNED_EN
    .iSigned (1'b0),
`endif
    .iData_a (iA8),
    .iData_b (iB8),
    .oBusy   (oBusy8),
    .oDone   (oDone8),
    .oData   (oData8),
    .oCycles (oCycles8)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: scan 8-bit slices from the top; the first unequal one decides. Top slice may be signed.
  function automatic void refCmp(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 output logic [2:0] code, output int k);
    int  va;
    int  vb;
    bit  found;
    code  = 3'b010;
    k     = 4;
    found = 1'b0;
    for (int s = 3; s >= 0 && !found; s--) begin
      va = int'(a[s*8 +: 8]);
      vb = int'(b[s*8 +: 8]);
      if (sgn && s == 3) begin
        if (va >= 128) va = va - 256;
        if (vb >= 128) vb = vb - 256;
      end
      if (va != vb) begin
        code  = (va > vb) ? 3'b100 : 3'b001;
        k     = 4 - s;
        found = 1'b1;
      end
    end
  endfunction

  // Model state: busy countdown, pending result, held result, done pulse
  logic       mBusy   = 1'b0;
  logic       mDone   = 1'b0;
  logic [2:0] mData   = 3'b000;
  int         mCyc    = 0;
  int         mRemain = 0;
  logic [2:0] pData;
  int         pK;
  logic       sgnEff;

  always @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      mBusy   = 1'b0;
      mDone   = 1'b0;
      mData   = 3'b000;
      mCyc    = 0;
      mRemain = 0;
    end else begin
      mDone = 1'b0;
      if (mBusy) begin
        mRemain = mRemain - 1;
        if (mRemain == 0) begin
          mBusy = 1'b0;
          mDone = 1'b1;
          mData = pData;
          mCyc  = pK;
        end
      end else if (iStart) begin
`ifdef DATA_COMPARE_SIGNED_EN
        sgnEff = iSignedIn;
`else
        sgnEff = 1'b0;
`endif
        refCmp(iData_a, iData_b, sgnEff, pData, pK);
        mRemain = pK;
        mBusy   = 1'b1;
      end
    end
  end

  // Every falling edge: DUT outputs must equal the model
  always @(negedge iClk) begin
    if (chkEn) begin
      check("cyc_busy",   {31'b0, oBusy}, {31'b0, mBusy});
      check("cyc_done",   {31'b0, oDone}, {31'b0, mDone});
      check("cyc_data",   {29'b0, oData}, {29'b0, mData});
      check("cyc_cycles", {29'b0, oCycles}, mCyc);
    end
  end

  // One start pulse; checks result, latency in edges and busy duration against literals
  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic [2:0] expD, input int expK, input string nm);
    int edges;
    int busyCnt;
    bit got;
    @(negedge iClk);
    iData_a   = a;
    iData_b   = b;
    iSignedIn = sgn;
    iStart    = 1'b1;
    @(posedge iClk);
    #1;
    iStart  = 1'b0;
    busyCnt = oBusy ? 1 : 0;
    edges   = 0;
    got     = 1'b0;
    while (!got && edges < 20) begin
      @(posedge iClk);
      #1;
      edges++;
      if (oDone) got = 1'b1;
      else if (oBusy) busyCnt++;
    end
    check({nm, "_done_seen"}, {31'b0, got}, 32'd1);
    check({nm, "_latency"}, edges, expK);
    check({nm, "_data"}, {29'b0, oData}, {29'b0, expD});
    check({nm, "_cycles"}, {29'b0, oCycles}, expK);
    check({nm, "_busy_len"}, busyCnt, expK);
  endtask

  task automatic runOp8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] expD, input string nm);
    int edges;
    bit got;
    @(negedge iClk);
    iA8     = a;
    iB8     = b;
    iStart8 = 1'b1;
    @(posedge iClk);
    #1;
    iStart8 = 1'b0;
    edges   = 0;
    got     = 1'b0;
    while (!got && edges < 20) begin
      @(posedge iClk);
      #1;
      edges++;
      if (oDone8) got = 1'b1;
    end
    check({nm, "_latency"}, edges, 32'd1);
    check({nm, "_data"}, {29'b0, oData8}, {29'b0, expD});
    check({nm, "_cycles"}, {31'b0, oCycles8}, 32'd1);
  endtask

  logic [2:0] rc;
  int         rk;

  initial begin
    iRst      = 1'b1;
    iStart    = 1'b0;
    iSignedIn = 1'b0;
    iData_a   = '0;
    iData_b   = '0;
    iStart8   = 1'b0;
    iA8       = '0;
    iB8       = '0;

    // Pin the reference model itself
    refCmp(32'h12345679, 32'h12345678, 1'b0, rc, rk);
    check("ref_gt_code", {29'b0, rc}, 32'h4);
    check("ref_gt_k", rk, 32'd4);
    refCmp(32'h80000000, 32'h00000001, 1'b1, rc, rk);
    check("ref_signed_code", {29'b0, rc}, 32'h1);

    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    #1;
    check("rst_busy",   {31'b0, oBusy}, 32'd0);
    check("rst_done",   {31'b0, oDone}, 32'd0);
    check("rst_data",   {29'b0, oData}, 32'd0);
    check("rst_cycles", {29'b0, oCycles}, 32'd0);
    chkEn = 1'b1;

    // Top slice differs
    runOp(32'hA6A6A6A6, 32'hFFA6A6A6, 1'b0, 3'b001, 1, "t1_lt_top");
    // Full walk, equal and greater in the last slice
    runOp(32'h12345678, 32'h12345678, 1'b0, 3'b010, 4, "t2_eq");
    runOp(32'h12345679, 32'h12345678, 1'b0, 3'b100, 4, "t2_gt_low");
    runOp(32'h00000001, 32'h00000002, 1'b0, 3'b001, 4, "lt_low");
    runOp(32'h00FF0000, 32'h00FE7777, 1'b0, 3'b100, 2, "gt_slice2");
    runOp(32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, 3'b100, 1, "gt_msb");

    // iStart held through CMP, operands changed mid-operation, restart straight from DONE
    @(negedge iClk);
    iData_a = 32'h12345679;
    iData_b = 32'h12345678;
    iStart  = 1'b1;
    @(posedge iClk);
    #1;
    iData_a = 32'h00000000;
    iData_b = 32'h01000000;
    repeat (3) begin
      @(posedge iClk);
      #1;
      check("t3_no_early_done", {31'b0, oDone}, 32'd0);
    end
    @(posedge iClk);
    #1;
    check("t3_first_done", {31'b0, oDone}, 32'd1);
    check("t3_first_data", {29'b0, oData}, 32'h4);
    check("t3_first_cycles", {29'b0, oCycles}, 32'd4);
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    check("t3_restart_busy", {31'b0, oBusy}, 32'd1);
    check("t3_restart_done_low", {31'b0, oDone}, 32'd0);
    check("t3_hold_data", {29'b0, oData}, 32'h4);
    check("t3_hold_cycles", {29'b0, oCycles}, 32'd4);
    @(posedge iClk);
    #1;
    check("t3_second_done", {31'b0, oDone}, 32'd1);
    check("t3_second_data", {29'b0, oData}, 32'h1);
    check("t3_second_cycles", {29'b0, oCycles}, 32'd1);

    // Reset mid-compare aborts with no done pulse
    @(negedge iClk);
    iData_a = 32'h12345678;
    iData_b = 32'h12345678;
    iStart  = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    repeat (2) @(posedge iClk);
    #2;
    iRst = 1'b1;
    #1;
    check("t4_rst_busy",   {31'b0, oBusy}, 32'd0);
    check("t4_rst_done",   {31'b0, oDone}, 32'd0);
    check("t4_rst_data",   {29'b0, oData}, 32'd0);
    check("t4_rst_cycles", {29'b0, oCycles}, 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    repeat (4) begin
      @(negedge iClk);
      #1;
      check("t4_no_done_after_abort", {31'b0, oDone}, 32'd0);
    end
    runOp(32'h12345678, 32'h12345678, 1'b0, 3'b010, 4, "t4_after_rst");

    // Signed top slice
`ifdef DATA_COMPARE_SIGNED_EN
    runOp(32'h80000000, 32'h00000001, 1'b1, 3'b001, 1, "t5_signed");
    runOp(32'h80000000, 32'h00000001, 1'b0, 3'b100, 1, "t5_unsigned");
    runOp(32'hFF000005, 32'hFF000003, 1'b1, 3'b100, 4, "t5_signed_low");
`else
    runOp(32'h80000000, 32'h00000001, 1'b0, 3'b100, 1, "t5_unsigned");
`endif

    // Single-slice build
    runOp8(8'hA6, 8'hFF, 3'b001, "t6_lt");
    runOp8(8'hA6, 8'h92, 3'b100, "t6_gt");
    runOp8(8'hA6, 8'hD6, 3'b001, "t6_lt2");
    runOp8(8'hA6, 8'hA6, 3'b010, "t6_eq");

    repeat (3) @(negedge iClk);
    chkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
